// File: rtl/calc_tx_scheduler.sv
// calc_tx_scheduler: round-robin sharing of one UART byte transmitter between
// keystroke echo, calculator result report and calculator error report.
// Each accepted request is formatted into an ASCII message (up to 7 bytes)
// and sent byte by byte, pacing each byte against the transmitter busy flag.
module calc_tx_scheduler #(
  parameter int unsigned CRLF       = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        echo_valid,
  input  logic [7:0]  echo_data,
  output logic        echo_ready,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic        res_overflow,
  output logic        res_ready,
  input  logic        err_valid,
  input  logic [3:0]  err_code,
  output logic        err_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  localparam int unsigned MSG_MAX   = 7;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TIMEOUT   = 4;
  localparam int unsigned GAP_LEN   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_BANG = 8'h21;
  localparam logic [7:0] CHR_E    = 8'h45;

  typedef enum logic [1:0] {
    REQ_ECHO = 2'd0,
    REQ_RES  = 2'd1,
    REQ_ERR  = 2'd2
  } req_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    LAUNCH  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5
  } state_e;

  state_e                        state_q, state_d;
  req_e                          ptr_q, ptr_d;
  req_e                          win_q, win_d;
  logic [MSG_MAX-1:0][7:0]       buf_q, buf_d;
  logic [IDX_W-1:0]              len_q, len_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          echo_ready_q, echo_ready_d;
  logic                          res_ready_q, res_ready_d;
  logic                          err_ready_q, err_ready_d;
  logic                          tx_start_q, tx_start_d;
  logic [7:0]                    tx_data_q, tx_data_d;

  req_e                          arb_pick;
  logic                          any_req;
  logic [IDX_W-1:0]              msg_end;

  // One nibble to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
  endfunction

  assign any_req = echo_valid | res_valid | err_valid;

  // Round-robin pick: scan starts at the requester after the last grant (echo -> err -> res -> echo).
  always_comb begin
    arb_pick = REQ_ECHO;
    case (ptr_q)
      REQ_ECHO: begin
        if (err_valid)      arb_pick = REQ_ERR;
        else if (res_valid) arb_pick = REQ_RES;
        else                arb_pick = REQ_ECHO;
      end
      REQ_ERR: begin
        if (res_valid)       arb_pick = REQ_RES;
        else if (echo_valid) arb_pick = REQ_ECHO;
        else                 arb_pick = REQ_ERR;
      end
      default: begin
        if (echo_valid)     arb_pick = REQ_ECHO;
        else if (err_valid) arb_pick = REQ_ERR;
        else                arb_pick = REQ_RES;
      end
    endcase
  end

  // Next-state, message formatting and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    buf_d        = buf_q;
    len_d        = len_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    echo_ready_d = 1'b0;
    res_ready_d  = 1'b0;
    err_ready_d  = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    msg_end      = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          win_d = arb_pick;
          case (arb_pick)
            REQ_ECHO: echo_ready_d = 1'b1;
            REQ_RES:  res_ready_d  = 1'b1;
            default:  err_ready_d  = 1'b1;
          endcase
          state_d = GRANT;
        end
      end

      GRANT: begin
        buf_d = '0;
        case (win_q)
          REQ_ECHO: begin
            buf_d[0] = echo_data;
            msg_end  = 3'd1;
          end
          REQ_RES: begin
            buf_d[0] = hex_ascii(res_data[15:12]);
            buf_d[1] = hex_ascii(res_data[11:8]);
            buf_d[2] = hex_ascii(res_data[7:4]);
            buf_d[3] = hex_ascii(res_data[3:0]);
            msg_end  = 3'd4;
            if (res_overflow) begin
              buf_d[4] = CHR_BANG;
              msg_end  = 3'd5;
            end
            if (CRLF != 0) begin
              buf_d[msg_end]                    = CHR_CR;
              buf_d[IDX_W'(msg_end + 3'd1)]     = CHR_LF;
              msg_end                           = IDX_W'(msg_end + 3'd2);
            end
          end
          default: begin
            buf_d[0] = CHR_E;
            buf_d[1] = hex_ascii(err_code);
            msg_end  = 3'd2;
            if (CRLF != 0) begin
              buf_d[2] = CHR_CR;
              buf_d[3] = CHR_LF;
              msg_end  = 3'd4;
            end
          end
        endcase
        len_d      = msg_end;
        ptr_d      = win_q;
        idx_d      = '0;
        tx_start_d = 1'b1;
        tx_data_d  = buf_d[0];
        state_d    = LAUNCH;
      end

      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end

      // Missing busy acknowledge is treated as a sent byte after the timeout.
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(len_q - 3'd1)) begin
            state_d = IDLE;
          end else begin
            idx_d      = IDX_W'(idx_q + 3'd1);
            tx_start_d = 1'b1;
            tx_data_d  = buf_q[IDX_W'(idx_q + 3'd1)];
            state_d    = LAUNCH;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any message in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= REQ_ECHO;
      win_q        <= REQ_ECHO;
      buf_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      echo_ready_q <= 1'b0;
      res_ready_q  <= 1'b0;
      err_ready_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      echo_ready_q <= echo_ready_d;
      res_ready_q  <= res_ready_d;
      err_ready_q  <= err_ready_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign echo_ready = echo_ready_q;
  assign res_ready  = res_ready_q;
  assign err_ready  = err_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_calc_tx_scheduler.sv
// Directed bench for calc_tx_scheduler: main instance (CRLF=1, GAP=2) plus a
// second instance (CRLF=0, GAP=0) for the no-terminator message length.
module tb_calc_tx_scheduler;

  localparam int unsigned GAP_A = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        echo_valid = 1'b0, res_valid = 1'b0, err_valid = 1'b0;
  logic [7:0]  echo_data = 8'h00;
  logic [15:0] res_data = 16'h0000;
  logic        res_overflow = 1'b0;
  logic [3:0]  err_code = 4'h0;
  logic        echo_ready, res_ready, err_ready, tx_start, tx_busy;
  logic [7:0]  tx_data;

  logic        res_valid_b = 1'b0, res_overflow_b = 1'b0;
  logic [15:0] res_data_b = 16'h0000;
  logic        echo_ready_b, res_ready_b, err_ready_b, tx_start_b, tx_busy_b;
  logic [7:0]  tx_data_b;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        busy_en = 1'b1;
  logic        hold_all = 1'b0;
  logic [3:0]  bcnt_a = 4'd0, bcnt_b = 4'd0;

  logic [7:0]  rx_q[$];
  logic [7:0]  rx_b[$];
  logic [7:0]  exp_q[$];
  int          gq[$];

  int          rdy_cyc = 0, start_cyc = 0, fall_cyc = 0;
  logic        first_pending = 1'b0, prev_busy = 1'b0;

  always #5 clock = ~clock;

  calc_tx_scheduler #(.CRLF(1), .GAP_CYCLES(GAP_A)) dut (
    .clock(clock), .reset_n(reset_n),
    .echo_valid(echo_valid), .echo_data(echo_data), .echo_ready(echo_ready),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow), .res_ready(res_ready),
    .err_valid(err_valid), .err_code(err_code), .err_ready(err_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  calc_tx_scheduler #(.CRLF(0), .GAP_CYCLES(0)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .echo_valid(1'b0), .echo_data(8'h00), .echo_ready(echo_ready_b),
    .res_valid(res_valid_b), .res_data(res_data_b), .res_overflow(res_overflow_b), .res_ready(res_ready_b),
    .err_valid(1'b0), .err_code(4'h0), .err_ready(err_ready_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b)
  );

  // Transmitter models: busy for 5 cycles starting the cycle after tx_start.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      bcnt_a <= 4'd0;
      bcnt_b <= 4'd0;
    end else begin
      if (tx_start && busy_en) bcnt_a <= 4'd5;
      else if (bcnt_a != 4'd0) bcnt_a <= bcnt_a - 4'd1;
      if (tx_start_b) bcnt_b <= 4'd5;
      else if (bcnt_b != 4'd0) bcnt_b <= bcnt_b - 4'd1;
    end
  end
  assign tx_busy   = (bcnt_a != 4'd0);
  assign tx_busy_b = (bcnt_b != 4'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: captures bytes and grants, checks launch latency and byte pacing.
  always @(negedge clock) begin
    if (echo_ready || res_ready || err_ready) begin
      check_eq("ready_onehot", 32'(echo_ready) + 32'(res_ready) + 32'(err_ready), 1);
      gq.push_back(err_ready ? 2 : (res_ready ? 1 : 0));
      rdy_cyc = cyc;
      first_pending = 1'b1;
    end
    if (tx_start) begin
      rx_q.push_back(tx_data);
      if (first_pending) check_eq("launch_lat", cyc - rdy_cyc, 1);
      else if (busy_en) check_eq("gap_after_busy", cyc - fall_cyc, GAP_A + 1);
      else check_eq("timeout_spacing", cyc - start_cyc, 7);
      first_pending = 1'b0;
      start_cyc = cyc;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    if (tx_start_b) rx_b.push_back(tx_data_b);
    if (echo_ready_b || res_ready_b || err_ready_b)
      check_eq("b_ready", {29'd0, echo_ready_b, res_ready_b, err_ready_b}, 3'b010);
  end

  task automatic step();
    @(negedge clock);
    #1;
    if (!hold_all) begin
      if (echo_ready) echo_valid = 1'b0;
      if (res_ready)  res_valid  = 1'b0;
      if (err_ready)  err_valid  = 1'b0;
      if (res_ready_b) res_valid_b = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag, input int which);
    int t0 = cyc;
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if ((which == 0 && echo_ready) || (which == 1 && res_ready) ||
          (which == 2 && err_ready) || (which == 3 && res_ready_b)) begin
        seen = 1'b1;
        check_eq({tag, "_ready_lat"}, cyc - t0, 1);
      end
    end
    check_eq({tag, "_ready_seen"}, 32'(seen), 1);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 3000 && rx_q.size() < n; i++) step();
    repeat (20) step();
  endtask

  task automatic cmp_bytes(input string tag);
    check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check_eq($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    rx_q.delete();
    gq.delete();
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_readys", {echo_ready, res_ready, err_ready}, 3'b000);
    check_eq("rst_b_tx_start", tx_start_b, 0);
    reset_n = 1'b1;
    step();

    // Result 0x1A2F, data changed after capture must not matter
    res_data = 16'h1A2F; res_overflow = 1'b0; res_valid = 1'b1;
    wait_ready("res1a2f", 1);
    step();
    res_data = 16'h0000;
    wait_bytes(6);
    exp_q = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    cmp_bytes("res1a2f");

    // Result 0xFFFF with overflow: 7 bytes
    res_data = 16'hFFFF; res_overflow = 1'b1; res_valid = 1'b1;
    wait_ready("resffff", 1);
    wait_bytes(7);
    res_overflow = 1'b0;
    exp_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h21, 8'h0D, 8'h0A};
    cmp_bytes("resffff");

    // Same message without CRLF, no gap: 5 bytes
    res_data_b = 16'hFFFF; res_overflow_b = 1'b1; res_valid_b = 1'b1;
    wait_ready("b_ffff", 3);
    repeat (150) step();
    rx_q = rx_b;
    exp_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h21};
    cmp_bytes("b_ffff");

    // Error and echo together after reset: error first
    do_reset();
    err_code = 4'hB; err_valid = 1'b1;
    echo_data = 8'h37; echo_valid = 1'b1;
    wait_bytes(5);
    exp_q = '{8'h45, 8'h42, 8'h0D, 8'h0A, 8'h37};
    cmp_bytes("err_echo");
    check_eq("err_echo_grants", gq.size(), 2);
    if (gq.size() == 2) begin
      check_eq("err_echo_g0", gq[0], 2);
      check_eq("err_echo_g1", gq[1], 0);
    end

    // All three held: err, res, echo, err, res, echo
    do_reset();
    echo_data = 8'h41; res_data = 16'h0009; err_code = 4'h3;
    hold_all = 1'b1;
    echo_valid = 1'b1; res_valid = 1'b1; err_valid = 1'b1;
    for (int i = 0; i < 3000 && gq.size() < 6; i++) step();
    hold_all = 1'b0;
    echo_valid = 1'b0; res_valid = 1'b0; err_valid = 1'b0;
    wait_bytes(22);
    check_eq("rr_grants", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) check_eq($sformatf("rr_g%0d", i), gq[i], 2 - (i % 3));
    exp_q = '{8'h45, 8'h33, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A, 8'h41,
              8'h45, 8'h33, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A, 8'h41};
    cmp_bytes("rr");

    // Transmitter never busy: timeout per byte, then back to IDLE
    busy_en = 1'b0;
    err_code = 4'hF; err_valid = 1'b1;
    wait_ready("timeout_err", 2);
    wait_bytes(4);
    exp_q = '{8'h45, 8'h46, 8'h0D, 8'h0A};
    cmp_bytes("timeout_err");
    echo_data = 8'h5A; echo_valid = 1'b1;
    wait_ready("timeout_echo", 0);
    wait_bytes(1);
    exp_q = '{8'h5A};
    cmp_bytes("timeout_echo");
    busy_en = 1'b1;

    // Reset during byte 3 of a result, then full resend
    do_reset();
    res_data = 16'h1A2F; res_valid = 1'b1; hold_all = 1'b1;
    for (int i = 0; i < 500 && rx_q.size() < 3; i++) step();
    reset_n = 1'b0;
    step();
    check_eq("midrst_tx_start", tx_start, 0);
    check_eq("midrst_tx_data", tx_data, 8'h00);
    check_eq("midrst_readys", {echo_ready, res_ready, err_ready}, 3'b000);
    check_eq("midrst_bytes", rx_q.size(), 3);
    reset_n = 1'b1;
    rx_q.delete();
    wait_ready("midrst_regrant", 1);
    hold_all = 1'b0; res_valid = 1'b0;
    wait_bytes(6);
    exp_q = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    cmp_bytes("midrst_resend");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
